// File: rtl/conversor_pkg.sv
// -----------------------------------------------------------------------------
// conversor_pkg
// Shared constants, state encoding and helpers for the BCD-to-binary
// temperature setpoint converter (conversor_bcd_binario).
//   TEMP_OFFSET / TEMP_MAX : accepted temperature window in degrees C
//   N_PASOS                : number of reverse double-dabble steps
//   estado_conv_t          : converter FSM states
//   valor_decimal()        : exact tens*10+units, used for the range check
// -----------------------------------------------------------------------------
package conversor_pkg;

   localparam logic [6:0] TEMP_OFFSET = 7'd20;
   localparam logic [6:0] TEMP_MAX    = 7'd51;
   localparam int         N_PASOS     = 6;

   // Step counter value seen during the last CONVIERTE cycle.
   localparam logic [2:0] PASO_FINAL  = 3'(N_PASOS - 1);

   typedef enum logic [1:0] {
      ESPERA_DECENAS  = 2'd0,
      ESPERA_UNIDADES = 2'd1,
      CONVIERTE       = 2'd2,
      AJUSTE          = 2'd3
   } estado_conv_t;

   // Full 7-bit decimal value; the shift-register result is only 6 bits wide
   // and wraps above 63, so the range check must not rely on it.
   function automatic logic [6:0] valor_decimal(input logic [3:0] decenas,
                                                input logic [3:0] unidades);
      return (7'(decenas) * 7'd10) + 7'(unidades);
   endfunction

endpackage

// File: rtl/paso_dabble_inverso.sv
// -----------------------------------------------------------------------------
// paso_dabble_inverso
// One combinational step of the reverse double-dabble: shift the 14-bit
// {tens, units, bin[5:0]} vector right by one, then subtract 3 from each BCD
// nibble that ended up >= 8.
//   entrada [13:0] : current shift-register contents
//   salida  [13:0] : contents after one step
// -----------------------------------------------------------------------------
module paso_dabble_inverso (
   input  logic [13:0] entrada,
   output logic [13:0] salida
);

   logic [13:0] desplazado;

   assign desplazado  = {1'b0, entrada[13:1]};
   assign salida[5:0] = desplazado[5:0];

   // Nibble 0 is the units digit (bits 9:6), nibble 1 the tens digit (13:10).
   // A nibble >= 8 after the shift received a "half ten" (value 5 scaled by
   // 16/2 = 8), so subtracting 3 restores a valid decimal weighting.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_nibble
         logic [3:0] nibble;
         assign nibble = desplazado[6 + 4*gi +: 4];
         assign salida[6 + 4*gi +: 4] = (nibble >= 4'd8) ? (nibble - 4'd3) : nibble;
      end
   endgenerate

endmodule

// File: rtl/conversor_bcd_binario.sv
// -----------------------------------------------------------------------------
// conversor_bcd_binario
// Sequential BCD-to-binary converter for temperature setpoint entry. Takes a
// tens digit then a units digit over a valid/ready handshake, converts them
// with a 6-step reverse double-dabble and outputs value-20 as a 5-bit code.
//   clk           : system clock, rising edge
//   rst           : asynchronous active-low reset
//   digito        : BCD digit offered
//   digito_valido : digito is valid this cycle
//   listo         : block accepts a digit this cycle
//   Temperatura   : offset code (value - 20), held until next good conversion
//   valido        : one-cycle pulse, Temperatura just updated
//   error         : one-cycle pulse, entry rejected
// Build option: define CONVERSOR_SATURA_EN to clamp out-of-range entries to
// 0 / 31 (pulsing valido) instead of rejecting them.
// -----------------------------------------------------------------------------
module conversor_bcd_binario
   import conversor_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] digito,
   input  logic       digito_valido,
   output logic       listo,
   output logic [4:0] Temperatura,
   output logic       valido,
   output logic       error
);

   estado_conv_t estado_q, estado_d;
   logic [3:0]   decenas_q, decenas_d;
   logic [6:0]   valor_q, valor_d;
   logic [13:0]  desp_q, desp_d;
   logic [2:0]   paso_q, paso_d;
   logic [4:0]   temp_q, temp_d;
   logic         valido_q, valido_d;
   logic         error_q, error_d;

   logic [13:0]  desp_paso;
   logic [5:0]   bin_menos_offset;

   paso_dabble_inverso u_paso (
      .entrada (desp_q),
      .salida  (desp_paso)
   );

   assign bin_menos_offset = desp_q[5:0] - 6'(TEMP_OFFSET);

   // Ready depends only on state so it is high straight out of reset.
   assign listo       = (estado_q == ESPERA_DECENAS) || (estado_q == ESPERA_UNIDADES);
   assign Temperatura = temp_q;
   assign valido      = valido_q;
   assign error       = error_q;

   always_comb begin
      estado_d  = estado_q;
      decenas_d = decenas_q;
      valor_d   = valor_q;
      desp_d    = desp_q;
      paso_d    = paso_q;
      temp_d    = temp_q;
      valido_d  = 1'b0;
      error_d   = 1'b0;

      case (estado_q)
         ESPERA_DECENAS: begin
            if (digito_valido) begin
               if (digito <= 4'd9) begin
                  decenas_d = digito;
                  estado_d  = ESPERA_UNIDADES;
               end else begin
                  error_d = 1'b1;
               end
            end
         end

         ESPERA_UNIDADES: begin
            if (digito_valido) begin
               if (digito <= 4'd9) begin
                  desp_d   = {decenas_q, digito, 6'b0};
                  valor_d  = valor_decimal(decenas_q, digito);
                  paso_d   = 3'd0;
                  estado_d = CONVIERTE;
               end else begin
                  error_d  = 1'b1;
                  estado_d = ESPERA_DECENAS;
               end
            end
         end

         CONVIERTE: begin
            desp_d = desp_paso;
            paso_d = paso_q + 3'd1;
            if (paso_q == PASO_FINAL) begin
               estado_d = AJUSTE;
            end
         end

         AJUSTE: begin
            estado_d = ESPERA_DECENAS;
            if ((valor_q >= TEMP_OFFSET) && (valor_q <= TEMP_MAX)) begin
               temp_d   = bin_menos_offset[4:0];
               valido_d = 1'b1;
            end else begin
`ifdef CONVERSOR_SATURA_EN
               temp_d   = (valor_q < TEMP_OFFSET) ? 5'd0 : 5'd31;
               valido_d = 1'b1;
`else
               error_d  = 1'b1;
`endif
            end
         end

         default: begin
            estado_d = ESPERA_DECENAS;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado_q  <= ESPERA_DECENAS;
         decenas_q <= 4'd0;
         valor_q   <= 7'd0;
         desp_q    <= 14'd0;
         paso_q    <= 3'd0;
         temp_q    <= 5'd0;
         valido_q  <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         decenas_q <= decenas_d;
         valor_q   <= valor_d;
         desp_q    <= desp_d;
         paso_q    <= paso_d;
         temp_q    <= temp_d;
         valido_q  <= valido_d;
         error_q   <= error_d;
      end
   end

endmodule

// File: tb/tb_conversor_bcd_binario.sv
// -----------------------------------------------------------------------------
// tb_conversor_bcd_binario
// Directed-vector bench for conversor_bcd_binario. Expected responses are
// queued when stimulus is issued; a monitor pops and compares whenever the
// DUT pulses valido or error.
// -----------------------------------------------------------------------------
module tb_conversor_bcd_binario;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] digito = 4'd0;
   logic       digito_valido = 1'b0;
   logic       listo;
   logic [4:0] Temperatura;
   logic       valido;
   logic       error;

`ifdef CONVERSOR_SATURA_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic       es_error;
      logic [4:0] temp;
   } esperado_t;

   esperado_t cola[$];
   int n_vec = 0;
   int n_err = 0;

   conversor_bcd_binario dut (
      .clk           (clk),
      .rst           (rst),
      .digito        (digito),
      .digito_valido (digito_valido),
      .listo         (listo),
      .Temperatura   (Temperatura),
      .valido        (valido),
      .error         (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string nombre, input int actual, input int requerido);
      n_vec++;
      if (actual !== requerido) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nombre, actual, requerido, $time);
      end
   endtask

   task automatic esperar(input logic es_err, input logic [4:0] temp);
      esperado_t e;
      e.es_error = es_err;
      e.temp     = temp;
      cola.push_back(e);
   endtask

   // Offer one digit and hold it until it is transferred. Returns #1 after the
   // accepting edge.
   task automatic enviar(input logic [3:0] d);
      int espera;
      espera        = 0;
      digito        = d;
      digito_valido = 1'b1;
      @(negedge clk);
      while (!listo && espera < 50) begin
         espera++;
         @(negedge clk);
      end
      if (!listo) check("listo_timeout", 0, 1);
      @(posedge clk);
      #1 digito_valido = 1'b0;
      $display("digit sent: 0x%h", d);
   endtask

   // Count cycles with listo low after the units edge, then check the result
   // pulse coincides with listo returning high.
   task automatic esperar_resultado(input int bajos);
      int cnt;
      cnt = 0;
      @(negedge clk);
      while (!listo && cnt < 20) begin
         cnt++;
         @(negedge clk);
      end
      check("ciclos_listo_bajo", cnt, bajos);
      check("pulso_con_listo", int'(valido | error), 1);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      esperado_t e;
      if (rst && (valido || error)) begin
         check("valido_y_error", int'(valido && error), 0);
         if (cola.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL pulso_inesperado: valido=%0b error=%0b Temperatura=%0d, expected no pulse",
                     valido, error, Temperatura);
         end else begin
            e = cola.pop_front();
            check("tipo_error", int'(error), int'(e.es_error));
            check("Temperatura", int'(Temperatura), int'(e.temp));
            $display("result: valido=%0b error=%0b Temperatura=%0d", valido, error, Temperatura);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset_listo", int'(listo), 1);
      check("reset_temp", int'(Temperatura), 0);
      check("reset_valido", int'(valido), 0);
      check("reset_error", int'(error), 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // 2,0 -> lowest in-range value.
      esperar(1'b0, 5'd0);
      enviar(4'd2);
      enviar(4'd0);
      esperar_resultado(7);

      // 5,1 -> highest in-range value.
      esperar(1'b0, 5'd31);
      enviar(4'd5);
      enviar(4'd1);
      esperar_resultado(7);

      // 3, idle, 7, with digito_valido held during conversion.
      esperar(1'b0, 5'd17);
      enviar(4'd3);
      repeat (3) @(posedge clk);
      #1;
      enviar(4'd7);
      digito        = 4'd8;
      digito_valido = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("listo_en_conversion", int'(listo), 0);
      end
      digito_valido = 1'b0;
      esperar_resultado(2);

      // 1,9 -> just below range.
      esperar(!SAT, SAT ? 5'd0 : 5'd17);
      enviar(4'd1);
      enviar(4'd9);
      esperar_resultado(7);

      // 9,9 -> 99 would wrap to 35 in 6 bits; must still be out of range.
      esperar(!SAT, SAT ? 5'd31 : 5'd17);
      enviar(4'd9);
      enviar(4'd9);
      esperar_resultado(7);

      // 5,2 -> just above range.
      esperar(!SAT, SAT ? 5'd31 : 5'd17);
      enviar(4'd5);
      enviar(4'd2);
      esperar_resultado(7);

      // Bad tens digit: error next cycle, still waiting for tens.
      esperar(1'b1, SAT ? 5'd31 : 5'd17);
      enviar(4'hA);
      check("error_decenas_inmediato", int'(error), 1);
      check("listo_tras_error", int'(listo), 1);
      @(posedge clk);
      #1;

      // 4 then bad units: error, back to tens; then 4,2 -> 22.
      esperar(1'b1, SAT ? 5'd31 : 5'd17);
      enviar(4'd4);
      enviar(4'hC);
      check("error_unidades_inmediato", int'(error), 1);
      @(posedge clk);
      #1;
      esperar(1'b0, 5'd22);
      enviar(4'd4);
      enviar(4'd2);
      esperar_resultado(7);

      // 4,5 then reset during the third conversion cycle.
      enviar(4'd4);
      enviar(4'd5);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_temp", int'(Temperatura), 0);
      check("abort_listo", int'(listo), 1);
      check("abort_valido", int'(valido), 0);
      check("abort_error", int'(error), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      check("abort_listo_final", int'(listo), 1);
      @(posedge clk);
      #1;

      // Fresh entry after the abort.
      esperar(1'b0, 5'd5);
      enviar(4'd2);
      enviar(4'd5);
      esperar_resultado(7);

      // 0,0 -> far below range.
      esperar(!SAT, SAT ? 5'd0 : 5'd5);
      enviar(4'd0);
      enviar(4'd0);
      esperar_resultado(7);

      repeat (5) @(posedge clk);
      #1;
      check("cola_vacia", cola.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
